time_keeper: RTL and testbench

- Running wall-clock core that sits directly downstream of the settings controller and consumes its `minutes_settings`, `hours_settings` and `set_time` outputs.
- Divides the 50 MHz system clock down to 1 Hz and keeps seconds, minutes and hours.
- Produces the `cur_minutes` and `cur_hours` values that are fed back to the settings controller and onward to the display path.
- Emits per-second and per-minute tick strobes for the alarm comparator and the display blinker.

---
 rtl/time_keeper.sv | 89 ++++++++
 tb/tb_time_keeper.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// time_keeper: 1 Hz prescaler driving seconds/minutes/hours counters,
// with an edge-triggered time load from the settings controller and tick strobes.
module time_keeper #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int MAX_MINUTES = 60,
   parameter int MAX_HOURS   = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           hold,
   input  logic                           set_time,
   input  logic [$clog2(MAX_MINUTES)-1:0] minutes_settings,
   input  logic [$clog2(MAX_HOURS)-1:0]   hours_settings,
   output logic [$clog2(MAX_MINUTES):0]   cur_seconds,
   output logic [$clog2(MAX_MINUTES):0]   cur_minutes,
   output logic [$clog2(MAX_HOURS):0]     cur_hours,
   output logic                           sec_tick,
   output logic                           min_tick,
   output logic                           load_err
);
   localparam int PW = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
   localparam int MW = $clog2(MAX_MINUTES) + 1;
   localparam int HW = $clog2(MAX_HOURS) + 1;
   logic [PW-1:0] pre_q, pre_d;
   logic [MW-1:0] sec_q, sec_d, min_q, min_d;
   logic [HW-1:0] hr_q, hr_d;
   logic          set_time_prev_q, set_time_prev_d;
   logic          sec_tick_q, sec_tick_d, min_tick_q, min_tick_d, load_err_q, load_err_d;
   logic          load, load_ok, tick, sec_wrap, min_wrap, hr_wrap;
   assign load     = set_time & ~set_time_prev_q;
   assign load_ok  = 32'(minutes_settings) < MAX_MINUTES && 32'(hours_settings) < MAX_HOURS;
   assign tick     = ~hold && pre_q == PW'(CLK_FREQ - 1);
   assign sec_wrap = sec_q == MW'(MAX_MINUTES - 1);
   assign min_wrap = min_q == MW'(MAX_MINUTES - 1);
   assign hr_wrap  = hr_q == HW'(MAX_HOURS - 1);
   // A valid load outranks both hold and a coinciding terminal count.
   always_comb begin
      pre_d           = pre_q;
      sec_d           = sec_q;
      min_d           = min_q;
      hr_d            = hr_q;
      set_time_prev_d = set_time;
      sec_tick_d      = 1'b0;
      min_tick_d      = 1'b0;
      load_err_d      = load & ~load_ok;
      if (load && load_ok) begin
         pre_d = '0;
         sec_d = '0;
         min_d = {1'b0, minutes_settings};
         hr_d  = {1'b0, hours_settings};
      end else if (tick) begin
         pre_d      = '0;
         sec_d      = sec_wrap ? '0 : sec_q + 1'b1;
         min_d      = sec_wrap ? (min_wrap ? '0 : min_q + 1'b1) : min_q;
         hr_d       = sec_wrap && min_wrap ? (hr_wrap ? '0 : hr_q + 1'b1) : hr_q;
         sec_tick_d = 1'b1;
         min_tick_d = sec_wrap;
      end else if (!hold) begin
         pre_d = pre_q + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q           <= '0;
         sec_q           <= '0;
         min_q           <= '0;
         hr_q            <= '0;
         set_time_prev_q <= 1'b0;
         sec_tick_q      <= 1'b0;
         min_tick_q      <= 1'b0;
         load_err_q      <= 1'b0;
      end else begin
         pre_q           <= pre_d;
         sec_q           <= sec_d;
         min_q           <= min_d;
         hr_q            <= hr_d;
         set_time_prev_q <= set_time_prev_d;
         sec_tick_q      <= sec_tick_d;
         min_tick_q      <= min_tick_d;
         load_err_q      <= load_err_d;
      end
   end
   assign cur_seconds = sec_q;
   assign cur_minutes = min_q;
   assign cur_hours   = hr_q;
   assign sec_tick    = sec_tick_q;
   assign min_tick    = min_tick_q;
   assign load_err    = load_err_q;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: scoreboard bench for time_keeper with a 4-cycle second.
module tb_time_keeper;
   localparam int CF = 4;
   typedef struct packed {
      logic [5:0] h;
      logic [6:0] m;
      logic [6:0] s;
      logic       st;
      logic       mt;
      logic       le;
   } snap_t;
   typedef struct {
      string name;
      snap_t v;
   } exp_t;
   logic       clk = 1'b0, rst = 1'b1, hold = 1'b0, set_time = 1'b0;
   logic [5:0] minutes_settings = '0;
   logic [4:0] hours_settings = '0;
   logic [6:0] cur_seconds, cur_minutes;
   logic [5:0] cur_hours;
   logic       sec_tick, min_tick, load_err;
   int         n_cmp = 0, n_err = 0;
   exp_t       sb[$];
   time_keeper #(.CLK_FREQ(CF), .MAX_MINUTES(60), .MAX_HOURS(24)) dut (
      .clk(clk), .rst(rst), .hold(hold), .set_time(set_time),
      .minutes_settings(minutes_settings), .hours_settings(hours_settings),
      .cur_seconds(cur_seconds), .cur_minutes(cur_minutes), .cur_hours(cur_hours),
      .sec_tick(sec_tick), .min_tick(min_tick), .load_err(load_err)
   );
   always #5 clk = ~clk;
   // Wall-clock model: k edges after a load/reset at time base (seconds).
   function automatic snap_t model(int base, int k, bit le);
      snap_t r;
      int t;
      t    = (base + k / CF) % 86400;
      r.h  = 6'(t / 3600);
      r.m  = 7'((t / 60) % 60);
      r.s  = 7'(t % 60);
      r.st = k > 0 && k % CF == 0;
      r.mt = r.st && t % 60 == 0;
      r.le = le;
      return r;
   endfunction
   function automatic snap_t obs();
      return {cur_hours, cur_minutes, cur_seconds, sec_tick, min_tick, load_err};
   endfunction
   function automatic string fmt(snap_t v);
      return $sformatf("%0d:%0d:%0d st=%b mt=%b le=%b", v.h, v.m, v.s, v.st, v.mt, v.le);
   endfunction
   task automatic test_reset();
      exp_t e;
      snap_t o;
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         sb.push_back('{"pre_rst_count", model(0, k, 0)});
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
      end
      rst = 1'b1;
      sb.push_back('{"async_rst", '0});
      #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e.v) begin n_err++; $display("FAIL %s got %s exp %s", e.name, fmt(o), fmt(e.v)); end
      sb.push_back('{"rst_held", '0});
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e.v) begin n_err++; $display("FAIL %s got %s exp %s", e.name, fmt(o), fmt(e.v)); end
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         sb.push_back('{"post_rst_count", model(0, k, 0)});
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
      end
   endtask
   task automatic test_rollover();
      exp_t e;
      snap_t o;
      int base = 23 * 3600 + 59 * 60;
      minutes_settings = 6'd59; hours_settings = 5'd23; set_time = 1'b1;
      for (int k = 0; k <= 60 * CF; k++) begin
         sb.push_back('{"rollover", model(base, k, 0)});
         @(negedge clk);
         set_time = 1'b0;
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
      end
   endtask
   task automatic test_level_set();
      exp_t e;
      snap_t o;
      int base = 7 * 3600 + 15 * 60;
      minutes_settings = 6'd15; hours_settings = 5'd7; set_time = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         sb.push_back('{"level_set", model(base, k, 0)});
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
         if (k == 5) begin minutes_settings = 6'd40; hours_settings = 5'd9; end
         if (k == 19) set_time = 1'b0;
      end
   endtask
   task automatic test_invalid_load();
      exp_t e;
      snap_t o;
      int base = 10 * 3600 + 20 * 60;
      minutes_settings = 6'd20; hours_settings = 5'd10; set_time = 1'b1;
      for (int k = 0; k <= 14; k++) begin
         sb.push_back('{"invalid_load", model(base, k, k == 7 || k == 9 || k == 12)});
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
         set_time = k == 6 || k == 8 || k == 11;
         if (k == 6) begin minutes_settings = 6'd61; hours_settings = 5'd3; end
         if (k == 8) begin minutes_settings = 6'd10; hours_settings = 5'd25; end
         if (k == 11) begin minutes_settings = 6'd63; hours_settings = 5'd31; end
      end
      set_time = 1'b0;
   endtask
   task automatic test_collision();
      exp_t e;
      snap_t o;
      int base = 3600 + 2 * 60;
      minutes_settings = 6'd2; hours_settings = 5'd1; set_time = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         sb.push_back('{"coll_pre", model(base, k, 0)});
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
         set_time = k == 3;
      end
      minutes_settings = 6'd34; hours_settings = 5'd12;
      base = 12 * 3600 + 34 * 60;
      for (int k = 0; k <= 8; k++) begin
         sb.push_back('{"collision", model(base, k, 0)});
         @(negedge clk);
         set_time = 1'b0;
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
      end
   endtask
   task automatic test_hold();
      exp_t e;
      snap_t o;
      int base = 5 * 3600 + 5 * 60;
      minutes_settings = 6'd5; hours_settings = 5'd5; set_time = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         sb.push_back('{"hold_pre", model(base, k, 0)});
         @(negedge clk);
         set_time = 1'b0;
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
      end
      hold = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         sb.push_back('{"hold_frozen", model(base, 9, 0)});
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s c=%0d got %s exp %s", e.name, c, fmt(o), fmt(e.v)); end
      end
      hold = 1'b0;
      for (int k = 10; k <= 16; k++) begin
         sb.push_back('{"hold_resume", model(base, k, 0)});
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
      end
   endtask
   task automatic test_load_in_hold();
      exp_t e;
      snap_t o;
      int base = 8 * 3600;
      hold = 1'b1; minutes_settings = 6'd0; hours_settings = 5'd8; set_time = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         sb.push_back('{"load_in_hold", model(base, 0, 0)});
         @(negedge clk);
         set_time = 1'b0;
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s c=%0d got %s exp %s", e.name, c, fmt(o), fmt(e.v)); end
      end
      hold = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         sb.push_back('{"after_hold_load", model(base, k, 0)});
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
      end
   endtask
   task automatic test_reset_mid_load();
      exp_t e;
      snap_t o;
      int base = 4 * 3600 + 30 * 60;
      rst = 1'b1; minutes_settings = 6'd30; hours_settings = 5'd4; set_time = 1'b1;
      sb.push_back('{"rst_mid_load", '0});
      #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e.v) begin n_err++; $display("FAIL %s got %s exp %s", e.name, fmt(o), fmt(e.v)); end
      sb.push_back('{"rst_hold_load", '0});
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e.v) begin n_err++; $display("FAIL %s got %s exp %s", e.name, fmt(o), fmt(e.v)); end
      rst = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         sb.push_back('{"load_at_release", model(base, k, 0)});
         @(negedge clk);
         set_time = 1'b0;
         e = sb.pop_front(); o = obs(); n_cmp++;
         if (o !== e.v) begin n_err++; $display("FAIL %s k=%0d got %s exp %s", e.name, k, fmt(o), fmt(e.v)); end
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      test_rollover();
      test_level_set();
      test_invalid_load();
      test_collision();
      test_hold();
      test_load_in_hold();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish, %0d compared", n_cmp);
      $fatal(1, "timeout");
   end
endmodule
